// File: rtl/digit_serial_mult.sv
// Digit-serial multiplier: emits P = a*b one DW-bit digit per transfer, LSB-first.
// Optional accumulate-in port c_in enabled by macro DIGIT_SERIAL_MULT_ACC_IN_EN.
module digit_serial_mult #(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 4,
  parameter int unsigned NDIG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        a,
  input  logic [NDIG*DW-1:0]   b,
`ifdef DIGIT_SERIAL_MULT_ACC_IN_EN
  input  logic [AW-1:0]        c_in,
`endif
  output logic                 busy,
  output logic [DW-1:0]        res_digit,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 done
);

  localparam int unsigned BW   = NDIG * DW;
  localparam int unsigned TW   = AW + DW;
  localparam int unsigned FDIG = AW / DW;
  localparam int unsigned TOT  = NDIG + FDIG;
  localparam int unsigned CW   = $clog2(TOT);

  typedef enum logic [1:0] {IDLE, MUL, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   digit_d;
  logic            valid_d, done_d, busy_d;

  logic [AW-1:0]   acc_init;
  logic [AW-1:0]   mul_a, mul_acc;
  logic [DW-1:0]   mul_dig;
  logic [TW-1:0]   t;
  logic [CW-1:0]   cnt_inc;
  logic            xfer, last_mul, last_dig;

`ifdef DIGIT_SERIAL_MULT_ACC_IN_EN
  assign acc_init = c_in;
`else
  assign acc_init = '0;
`endif

  // acc_q always holds the carry left after the digit currently presented,
  // so in IDLE the first step is computed straight from the inputs.
  assign mul_a   = (state_q == IDLE) ? a        : a_q;
  assign mul_acc = (state_q == IDLE) ? acc_init : acc_q;
  assign mul_dig = (state_q == IDLE) ? b[DW-1:0] : b_q[DW-1:0];
  assign t       = TW'(mul_acc) + TW'(mul_a) * TW'(mul_dig);

  assign xfer     = res_valid & res_ready;
  assign cnt_inc  = cnt_q + CW'(1);
  assign last_mul = (cnt_q == CW'(NDIG - 1));
  assign last_dig = (cnt_q == CW'(TOT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    digit_d = res_digit;
    valid_d = res_valid;
    done_d  = done;
    busy_d  = busy;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MUL;
          a_d     = a;
          b_d     = b >> DW;
          acc_d   = AW'(t >> DW);
          cnt_d   = '0;
          digit_d = t[DW-1:0];
          valid_d = 1'b1;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      MUL: begin
        if (xfer) begin
          cnt_d  = cnt_inc;
          done_d = (cnt_inc == CW'(TOT - 1));
          if (last_mul) begin
            state_d = FLUSH;
            digit_d = acc_q[DW-1:0];
            acc_d   = acc_q >> DW;
          end else begin
            digit_d = t[DW-1:0];
            acc_d   = AW'(t >> DW);
            b_d     = b_q >> DW;
          end
        end
      end

      FLUSH: begin
        if (xfer) begin
          if (last_dig) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            digit_d = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d   = cnt_inc;
            digit_d = acc_q[DW-1:0];
            acc_d   = acc_q >> DW;
            done_d  = (cnt_inc == CW'(TOT - 1));
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_digit <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_digit <= digit_d;
      res_valid <= valid_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/digit_serial_mult.md
DIGIT_SERIAL_MULT -- requirements
Module: digit_serial_mult

Interface
REQ-001 SHALL provide parameter AW, default 16, width in bits of operand A, and the number of high result bits.
REQ-002 SHALL provide parameter DW, default 4, width in bits of one B digit and of one result digit; AW SHALL be an integer multiple of DW.
REQ-003 SHALL provide parameter NDIG, default 4, number of B digits; B width = NDIG*DW.
REQ-004 SHALL provide port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL provide port a  input  AW  multiplicand, captured when start is accepted.
REQ-008 SHALL provide port b  input  NDIG*DW  multiplier, captured when start is accepted.
REQ-009 SHALL provide port busy  output  1  high from the cycle after acceptance until the last digit transfers.
REQ-010 SHALL provide port res_digit  output  DW  current result digit, LSB-first.
REQ-011 SHALL provide port res_valid  output  1  res_digit is valid.
REQ-012 SHALL provide port res_ready  input  1  consumer accepts; a digit transfers when res_valid and res_ready are both high.
REQ-013 SHALL provide port done  output  1  high together with the last digit, i.e. while res_valid is high for digit NDIG+AW/DW-1.

Function
REQ-014 SHALL implement states IDLE, MUL, FLUSH.
- IDLE->MUL on start.
- MUL->FLUSH after NDIG digit transfers.
- FLUSH->IDLE after AW/DW digit transfers.
REQ-015 SHALL, on acceptance, capture a, capture b, clear the digit counter and load acc_hi (AW bits) with 0.
REQ-016 SHALL, in MUL step k, form t = acc_hi + a*b[k*DW+:DW] (AW+DW bits, never overflows), present t[DW-1:0] as the digit and load acc_hi with t>>DW on transfer.
REQ-017 SHALL, in FLUSH, present acc_hi[DW-1:0] and shift acc_hi right by DW on transfer.
REQ-018 SHALL emit exactly NDIG+AW/DW digits per operation, forming P = a*b LSB-first.
REQ-019 SHALL register res_digit, res_valid and done; the first digit SHALL be valid in the cycle after acceptance.
REQ-020 SHALL, at full throughput (res_ready held high), deliver one digit per cycle and drop busy in the cycle after done.
REQ-021 SHALL, while res_valid && !res_ready, hold res_digit, res_valid, done and all state stable.
REQ-022 SHALL ignore start while busy, including a start in the same cycle as the final transfer.
REQ-023 SHALL treat b=0 or a=0 normally and emit all-zero digits with the full count.

Reset
REQ-024 SHALL, on rst asserted at any time including mid-operation, immediately force IDLE, busy=0, res_valid=0, done=0, res_digit=0, acc_hi=0 and counter=0, discarding any operation in progress.
REQ-025 SHALL accept a new start from the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, when macro DIGIT_SERIAL_MULT_ACC_IN_EN is defined, add port c_in  input  AW, captured on acceptance into acc_hi so that P = a*b + c_in (no overflow, same digit count).
REQ-027 SHALL, without DIGIT_SERIAL_MULT_ACC_IN_EN, omit port c_in and load acc_hi with 0.

Verification (AW=16, DW=4, NDIG=4)
REQ-028 Scenario: a=0xFFFF, b=0xFFFF, res_ready=1 -> digits 1,0,0,0,E,F,F,F on 8 consecutive cycles, starting the cycle after start; done with the final F.
REQ-029 Scenario: a=0x1234, b=0x0001 -> digits 4,3,2,1,0,0,0,0.
REQ-030 Scenario: case of REQ-028 with res_ready low for 3 cycles while digit 2 is presented -> digit 0 held stable; done delayed by exactly 3 cycles; sequence unchanged.
REQ-031 Scenario: start pulsed again mid-operation with a=0x0001, b=0x0001 -> ignored; first result unchanged; new start after busy falls -> digits 1,0,0,0,0,0,0,0.
REQ-032 Scenario: rst asserted during FLUSH -> outputs zero in the same cycle; next start with a=0x0002, b=0x0003 -> digits 6,0,0,0,0,0,0,0.
REQ-033 Scenario (DIGIT_SERIAL_MULT_ACC_IN_EN): a=0xFFFF, b=0xFFFF, c_in=0xFFFF -> digits 0,0,0,0,F,F,F,F.
